fetch_unit: RTL and testbench

Instruction fetch front end for the single-cycle MIPS core, sitting directly upstream of decode/execute: it owns the word-addressed PC, issues requests to instruction memory, and buffers returned instructions in a small in-order prefetch queue. Decode consumes instructions with a valid/ready handshake. Branch, jump and `jr` targets come back as a redirect that flushes the queue and squashes in-flight fetches.

---
 rtl/fetch_unit.sv | 192 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end for the single-cycle MIPS core.
//
// Owns the word-addressed fetch PC. Issues requests to instruction memory and
// buffers returned words in an in-order prefetch queue that decode drains with
// a valid/ready handshake. A redirect (taken branch, jump, jr) flushes the
// queue, moves the PC and marks every in-flight request as squashed so its
// response is thrown away when it arrives.
//
// Parameters:
//   DEPTH    : prefetch queue entries and in-flight request limit (power of two, >= 2)
//   RESET_PC : fetch address after reset
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   imem_req/addr/rdy   : request channel to instruction memory (word address)
//   imem_rvalid/rdata   : in-order response channel
//   inst_valid/data/pc  : queue head presented to decode
//   inst_pc_4           : inst_pc + 1 (link value)
//   inst_ready          : decode consumes the head this cycle
//   redirect_valid/pc   : new fetch address, flushes everything in flight
//
// Optional feature (macro FETCH_PERF_EN):
//   perf_fetched  : number of queue pushes
//   perf_squashed : discarded responses plus entries flushed by redirects
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_4,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 2;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d;

  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] tag_mem [DEPTH];

  logic [SW-1:0] credits_used;
  logic          accept;
  logic          pop;
  logic          resp_live;
  logic          push;

  // Every queue slot is reserved from the moment its request is accepted,
  // including requests that will be squashed, so the queue can never overflow.
  assign credits_used = SW'(count_q) + SW'(outstanding_q) + SW'(drop_q);
  assign imem_req     = !rst && (credits_used < DEPTH_S);
  assign imem_addr    = fetch_pc_q;

  assign accept    = imem_req && imem_rdy;
  assign pop       = inst_valid && inst_ready;
  assign resp_live = imem_rvalid && (drop_q == '0);
  // A response landing in a redirect cycle belongs to the old path.
  assign push      = resp_live && !redirect_valid;

  // Head is driven straight from registered state; empty queue reads as zero.
  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? q_instr[rd_ptr_q] : 32'd0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr_q]    : 32'd0;
  assign inst_pc_4  = inst_pc + 32'd1;

  // The tag FIFO holds the address of every accepted request, squashed or not,
  // and is popped by every response, so it stays aligned with memory order.
  assign tag_wr_d = tag_wr_q + PW'(accept);
  assign tag_rd_d = tag_rd_q + PW'(imem_rvalid);

  always_comb begin
    fetch_pc_d    = fetch_pc_q + (accept ? 32'd1 : 32'd0);
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_pc;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = '0;
      // Everything still in flight (plus a request accepted now) gets dropped;
      // the response arriving now, live or already squashed, is retired here.
      drop_d        = drop_q + outstanding_q + CW'(accept) - CW'(imem_rvalid);
    end else begin
      outstanding_d = outstanding_q + CW'(accept) - CW'(resp_live);
      if (imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  // Storage arrays carry no reset; their contents are only visible through
  // count_q/pointers, which are reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_instr[wr_ptr_q] <= imem_rdata;
      q_pc[wr_ptr_q]    <= tag_mem[tag_rd_q];
    end
    if (!rst && accept) begin
      tag_mem[tag_wr_q] <= fetch_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_squashed_q, perf_squashed_d;

  always_comb begin
    perf_fetched_d  = perf_fetched_q + (push ? 32'd1 : 32'd0);
    perf_squashed_d = perf_squashed_q;
    if (imem_rvalid && (redirect_valid || (drop_q != '0))) begin
      perf_squashed_d = perf_squashed_d + 32'd1;
    end
    // An entry popped in the redirect cycle was consumed, not flushed.
    if (redirect_valid) begin
      perf_squashed_d = perf_squashed_d + 32'(count_q) - (pop ? 32'd1 : 32'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q  <= 32'd0;
      perf_squashed_q <= 32'd0;
    end else begin
      perf_fetched_q  <= perf_fetched_d;
      perf_squashed_q <= perf_squashed_d;
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- scoreboard bench for fetch_unit.
// Reference model: after reset or a redirect to address A, decode must see the
// words A, A+1, A+2, ... in order, each carrying the memory contents of its
// address. Memory is modelled with in-order responses of random latency.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_4;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_pc_4(inst_pc_4), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- memory model ----------------
  typedef struct { logic [31:0] data; int due; } mresp_t;
  mresp_t mq[$];
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] next_pc = RESET_PC;
  logic        redir_prev = 1'b0;
  logic [31:0] redir_tgt = 32'd0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_addr = 32'd0;
  int          delivered = 0;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      next_pc    = RESET_PC;
      redir_prev = 1'b0;
      hold_prev  = 1'b0;
    end else begin
      mresp_t m;
      logic [31:0] e;
      if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
      if (imem_req && imem_rdy) begin
        m.data = mem_word(imem_addr);
        m.due  = cyc + int'($urandom_range(lat_max, lat_min));
        mq.push_back(m);
      end
      if (redir_prev) begin
        check("redir_addr", imem_addr, redir_tgt);
        check("redir_flush", 32'(inst_valid), 32'd0);
      end else if (hold_prev) begin
        check("req_hold", 32'(imem_req), 32'd1);
        check("addr_hold", imem_addr, hold_addr);
      end
      if (inst_valid && inst_ready) begin
        while (exp_q.size() < DEPTH) begin
          exp_q.push_back(next_pc);
          next_pc = next_pc + 32'd1;
        end
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst_data", inst_data, mem_word(e));
        check("inst_pc_4", inst_pc_4, e + 32'd1);
        delivered++;
      end
      if (redirect_valid) begin
        exp_q.delete();
        next_pc = redirect_pc;
      end
      redir_prev = redirect_valid;
      redir_tgt  = redirect_pc;
      hold_prev  = imem_req && !imem_rdy && !redirect_valid;
      hold_addr  = imem_addr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply_reset();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    imem_rdy       = 1'b0;
    inst_ready     = 1'b0;
    rst            = 1'b1;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_pc_4", inst_pc_4, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (inst_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for inst_valid actual=0 required=1", name);
    end
  endtask

  initial begin
    int acc;
    int lat;
    int d0;
    logic [31:0] s0;

    // 1: streaming after reset, L=1
    lat_min = 1; lat_max = 1;
    apply_reset();
    imem_rdy = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t1_addr", imem_addr, RESET_PC + 32'(k));
      if (k >= 2) begin
        check("t1_valid", 32'(inst_valid), 32'd1);
        check("t1_pc", inst_pc, RESET_PC + 32'(k - 2));
      end
    end

    // 2: decode stalled -> exactly DEPTH requests, then drain in order
    apply_reset();
    imem_rdy = 1'b1; inst_ready = 1'b0;
    acc = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req && imem_rdy) acc++;
    end
    check("t2_accepted", 32'(acc), 32'(DEPTH));
    check("t2_req_low", 32'(imem_req), 32'd0);
    check("t2_head_pc", inst_pc, RESET_PC);
    d0 = delivered;
    @(posedge clk); #1 inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("t2_drained", 32'(delivered - d0 >= DEPTH), 32'd1);

    // 3: redirect with requests in flight, L=3
    lat_min = 3; lat_max = 3;
    apply_reset();
    imem_rdy = 1'b1; inst_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    check("t3_pre_empty", 32'(inst_valid), 32'd0);
`ifdef FETCH_PERF_EN
    s0 = perf_squashed;
`else
    s0 = 32'd0;
`endif
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_valid("t3_wait", lat);
    check("t3_latency", 32'(lat), 32'd5);
    check("t3_first_pc", inst_pc, 32'h40);
`ifdef FETCH_PERF_EN
    check("t3_squashed", perf_squashed - s0, 32'd3);
`else
    check("t3_no_perf", s0, 32'd0 + 32'(lat == 5 ? 0 : 1));
`endif

    // 4: redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    apply_reset();
    imem_rdy = 1'b1; inst_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    check("t4_pre_rvalid", 32'(imem_rvalid), 32'd1);
    check("t4_pre_valid", 32'(inst_valid), 32'd1);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_empty", 32'(inst_valid), 32'd0);
    check("t4_addr", imem_addr, 32'h200);

    // 5: back-to-back redirects, last one wins
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h10;
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_valid("t5_wait", lat);
    check("t5_first_pc", inst_pc, 32'h20);

    // 6: reset with a full queue
    inst_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_full_valid", 32'(inst_valid), 32'd1);
    check("t6_full_noreq", 32'(imem_req), 32'd0);
    apply_reset();
    imem_rdy = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    check("t6_restart_addr", imem_addr, RESET_PC);
    check("t6_restart_req", 32'(imem_req), 32'd1);

    // 7: randomized traffic
    lat_min = 1; lat_max = 4;
    d0 = delivered;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom % 1000 == 0) begin
        apply_reset();
      end
      imem_rdy   = ($urandom % 10) < 7;
      inst_ready = ($urandom % 10) < 7;
      if ($urandom % 32 == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom % 4 == 0) ? 32'hFFFF_FFFE : $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (5) @(posedge clk);
    check("rand_progress", 32'(delivered - d0 > 500), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
